// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and matrix geometry for the matrix ALU sequencer.
package alu_seq_pkg;
    localparam int N_ELEM = 25;
    localparam int ELEM_W = 8;
    localparam int MAT_W  = N_ELEM * ELEM_W;

    localparam logic [2:0] OP_ADD       = 3'd0;
    localparam logic [2:0] OP_SUB       = 3'd1;
    localparam logic [2:0] OP_NEG       = 3'd2;
    localparam logic [2:0] OP_TRANSPOSE = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic logic op_binary(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_TRANSPOSE;
    endfunction
endpackage

// File: rtl/alu_seq_counter.sv
// Element counter (0..49) with matrix terminal counts and base+offset address generation.
// Latency: count registered, address combinational from the next count value.
// Backpressure: none; advances only when the sequencer asserts inc.
module alu_seq_counter
    import alu_seq_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base,
    output logic [5:0]        cnt,
    output logic [5:0]        cnt_nxt,
    output logic              tc_24,
    output logic              tc_49,
    output logic [ADDR_W-1:0] addr
);
    logic [5:0] offset;

    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (inc)
            cnt_nxt = cnt + 6'd1;
        // Second operand restarts at offset 0 from its own base.
        offset = (cnt_nxt >= 6'(N_ELEM)) ? cnt_nxt - 6'(N_ELEM) : cnt_nxt;
    end

    assign addr  = base + ADDR_W'(offset);
    assign tc_24 = (cnt == 6'(N_ELEM - 1));
    assign tc_49 = (cnt == 6'(2 * N_ELEM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end
endmodule

// File: rtl/alu_sequencer.sv
// Sequencer: fetches operand matrices byte-wise, runs the external ALU, writes the result back.
// Latency: 78 cycles binary, 53 unary, 1 illegal opcode (start edge to done pulse).
// Backpressure: none; start is ignored while busy, memory is fixed 1-cycle read latency.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op_code,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [ADDR_W-1:0] c_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ELEM_W-1:0] mem_wdata,
    input  logic [ELEM_W-1:0] mem_rdata,
    output logic [2:0]        alu_op,
    output logic [MAT_W-1:0]  A_flat,
    output logic [MAT_W-1:0]  B_flat,
    input  logic [MAT_W-1:0]  C_flat,
    input  logic              overflow_flag
);
    state_t            state;
    logic [ADDR_W-1:0] a_q, b_q, c_q;
    logic [MAT_W-1:0]  res_q;
    logic              rd_pend;
    logic [5:0]        rd_idx;
    logic [5:0]        b_idx;

    logic              cnt_clr, cnt_inc, rd_last;
    logic [ADDR_W-1:0] cnt_base, cnt_addr;
    logic [5:0]        cnt, cnt_nxt;
    logic              tc_24, tc_49;

    alu_seq_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .base    (cnt_base),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .tc_24   (tc_24),
        .tc_49   (tc_49),
        .addr    (cnt_addr)
    );

    assign rd_last = op_binary(alu_op) ? tc_49 : tc_24;
    assign b_idx   = rd_idx - 6'(N_ELEM);

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        cnt_base = a_q;
        case (state)
            ST_IDLE: begin
                cnt_clr  = 1'b1;
                cnt_base = a_addr;
            end
            ST_READ: begin
                cnt_inc  = !rd_last;
                cnt_base = (cnt_nxt >= 6'(N_ELEM)) ? b_q : a_q;
            end
            ST_EXEC: begin
                cnt_clr  = 1'b1;
                cnt_base = c_q;
            end
            ST_WRITE: begin
                cnt_inc  = !tc_24;
                cnt_base = c_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            alu_op    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            res_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    busy   <= 1'b1;
                    alu_op <= op_code;
                    a_q    <= a_addr;
                    b_q    <= b_addr;
                    c_q    <= c_addr;
                    err    <= !op_legal(op_code);
                    ovf    <= 1'b0;
                    if (!op_legal(op_code)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= cnt_addr;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_last) begin
                        mem_rd <= 1'b0;
                        state  <= ST_DRAIN;
                    end else begin
                        mem_addr <= cnt_addr;
                    end
                end
                ST_DRAIN: state <= ST_EXEC;
                ST_EXEC: begin
                    res_q     <= C_flat;
                    ovf       <= overflow_flag;
                    mem_wr    <= 1'b1;
                    mem_addr  <= cnt_addr;
                    mem_wdata <= C_flat[ELEM_W-1:0];
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (tc_24) begin
                        mem_wr <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        mem_addr  <= cnt_addr;
                        mem_wdata <= res_q[{cnt_nxt, 3'b000} +: ELEM_W];
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data lags its strobe by one cycle; remember which element it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_idx  <= '0;
            A_flat  <= '0;
            B_flat  <= '0;
        end else begin
            rd_pend <= mem_rd;
            rd_idx  <= cnt;
            if (rd_pend) begin
                if (rd_idx < 6'(N_ELEM))
                    A_flat[{rd_idx, 3'b000} +: ELEM_W] <= mem_rdata;
                else
                    B_flat[{b_idx, 3'b000} +: ELEM_W] <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural memory and ALU, matrix-level reference model.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op_code = '0;
    logic [7:0]   a_addr = '0, b_addr = '0, c_addr = '0;
    logic         busy, done, err, ovf;
    logic [7:0]   mem_addr;
    logic         mem_rd, mem_wr;
    logic [7:0]   mem_wdata;
    logic [7:0]   rdata_q = '0;
    logic [2:0]   alu_op;
    logic [199:0] A_flat, B_flat, C_flat;
    logic         overflow_flag;

    logic [7:0]   mem [256];
    logic [199:0] a_model = '0, b_model = '0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    // Matrix ALU over signed bytes; flag set when any element leaves -128..127.
    function automatic logic [200:0] alu_fn(input logic [2:0] op, input logic [199:0] a, input logic [199:0] b);
        logic [199:0] c;
        logic         v;
        int           x, y, s;
        c = '0;
        v = 1'b0;
        for (int i = 0; i < 25; i++) begin
            x = int'($signed(a[8*i +: 8]));
            y = int'($signed(b[8*i +: 8]));
            case (op)
                3'd0:    s = x + y;
                3'd1:    s = x - y;
                3'd2:    s = -x;
                3'd3:    s = int'($signed(a[8*((i % 5) * 5 + i / 5) +: 8]));
                default: s = 0;
            endcase
            if (s > 127 || s < -128) v = 1'b1;
            c[8*i +: 8] = s[7:0];
        end
        return {v, c};
    endfunction

    assign {overflow_flag, C_flat} = alu_fn(alu_op, A_flat, B_flat);

    alu_sequencer #(.ADDR_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .op_code       (op_code),
        .a_addr        (a_addr),
        .b_addr        (b_addr),
        .c_addr        (c_addr),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .ovf           (ovf),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (rdata_q),
        .alu_op        (alu_op),
        .A_flat        (A_flat),
        .B_flat        (B_flat),
        .C_flat        (C_flat),
        .overflow_flag (overflow_flag)
    );

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " ctl"}, {194'd0, busy, done, err, ovf, mem_rd, mem_wr}, '0);
        chk({tag, " bus"}, {181'd0, mem_addr, mem_wdata, alu_op}, '0);
        chk({tag, " A_flat"}, A_flat, '0);
        chk({tag, " B_flat"}, B_flat, '0);
    endtask

    // One command from start to the cycle after done; memory is served from the negedge.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input int poke_cyc, input int rst_cyc, input string tag);
        logic [199:0] sa, sb, ec;
        logic [200:0] r;
        logic         eovf, legal, binary, pend_v, aborted;
        logic [7:0]   pend;
        int           nr, exp_done, dn, nrd, nwr, bad, widx, nbad;
        legal  = (op <= 3'd3);
        binary = (op <= 3'd1);
        for (int i = 0; i < 25; i++) begin
            sa[8*i +: 8] = mem[8'(a + i)];
            sb[8*i +: 8] = mem[8'(b + i)];
        end
        r        = alu_fn(op, sa, binary ? sb : b_model);
        eovf     = r[200];
        ec       = r[199:0];
        nr       = legal ? (binary ? 50 : 25) : 0;
        exp_done = legal ? nr + 28 : 1;
        dn = -1; nrd = 0; nwr = 0; bad = 0;
        pend_v = 1'b0; pend = '0; aborted = 1'b0;

        @(negedge clk);
        start = 1'b1; op_code = op; a_addr = a; b_addr = b; c_addr = c;
        @(posedge clk);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            rdata_q = pend_v ? pend : 8'($urandom);
            pend_v  = mem_rd;
            if (mem_rd) pend = mem[mem_addr];
            if (mem_wr) mem[mem_addr] = mem_wdata;
            if (mem_rd === 1'b1) begin
                nrd++;
                if (mem_addr !== ((n <= 25) ? 8'(a + n - 1) : 8'(b + n - 26))) bad++;
            end
            if (mem_wr === 1'b1) begin
                nwr++;
                widx = n - nr - 3;
                if (widx < 0 || widx > 24) bad++;
                else if (mem_addr !== 8'(c + widx) || mem_wdata !== ec[8*widx +: 8]) bad++;
            end
            if (mem_rd !== (n <= nr)) bad++;
            if (mem_wr !== (legal && n >= nr + 3 && n <= nr + 27)) bad++;
            if (busy !== 1'b1 || done !== (n == exp_done)) bad++;
            if (n == 1) start = 1'b0;
            if (n == poke_cyc) begin
                start = 1'b1; op_code = 3'd5; a_addr = 8'($urandom); c_addr = 8'($urandom);
            end
            if (n == poke_cyc + 2) start = 1'b0;
            if (n == rst_cyc) begin
                aborted = 1'b1;
                break;
            end
            if (done === 1'b1) begin
                dn = n;
                break;
            end
        end

        if (aborted) begin
            chk({tag, " pre-reset protocol"}, 200'(bad), '0);
            #1 rst_n = 1'b0;
            #1 chk_reset_state({tag, " async reset"});
            @(negedge clk);
            rst_n   = 1'b1;
            a_model = '0;
            b_model = '0;
            return;
        end

        chk({tag, " done cycle"}, 200'(dn), 200'(exp_done));
        chk({tag, " read count"}, 200'(nrd), 200'(nr));
        chk({tag, " write count"}, 200'(nwr), legal ? 200'd25 : 200'd0);
        chk({tag, " protocol"}, 200'(bad), '0);
        chk({tag, " err"}, 200'(err), 200'(!legal));
        chk({tag, " ovf"}, 200'(ovf), 200'(legal && eovf));
        if (legal) a_model = sa;
        if (binary) b_model = sb;
        chk({tag, " A_flat"}, A_flat, a_model);
        chk({tag, " B_flat"}, B_flat, b_model);
        nbad = 0;
        if (legal)
            for (int i = 0; i < 25; i++)
                if (mem[8'(c + i)] !== ec[8*i +: 8]) nbad++;
        chk({tag, " result memory"}, 200'(nbad), '0);
        @(negedge clk);
        chk({tag, " idle after done"}, {198'd0, busy, done}, '0);
    endtask

    initial begin
        int nb;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            mem[i]           = 8'h10;
            mem[8'h20 + i]   = 8'h01;
        end
        run_cmd(OP_SUB, 8'h00, 8'h20, 8'h40, 0, 0, "sub");
        nb = 0;
        for (int i = 0; i < 25; i++) if (mem[8'h40 + i] !== 8'h0F) nb++;
        chk("sub bytes 0x0F", 200'(nb), '0);
        chk("sub ovf", 200'(ovf), '0);

        for (int i = 0; i < 25; i++) begin
            mem[8'h80 + i] = 8'h00;
            mem[8'hA0 + i] = 8'h00;
        end
        mem[8'h80] = 8'h7F;
        mem[8'hA0] = 8'h01;
        run_cmd(OP_ADD, 8'h80, 8'hA0, 8'hC0, 0, 0, "add ovf");
        chk("add C0", 200'(mem[8'hC0]), 200'h80);
        chk("add ovf set", 200'(ovf), 200'd1);
        repeat (3) @(negedge clk);
        chk("ovf held", 200'(ovf), 200'd1);

        run_cmd(OP_NEG, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, "neg");

        run_cmd(3'd5, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, "illegal");
        repeat (3) @(negedge clk);
        chk("err held", 200'(err), 200'd1);
        run_cmd(OP_TRANSPOSE, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, "transpose after illegal");

        run_cmd(OP_ADD, 8'($urandom), 8'($urandom), 8'hF0, 10, 0, "wrap and busy start");

        run_cmd(OP_ADD, 8'($urandom), 8'($urandom), 8'($urandom), 0, 60, "reset mid add");
        run_cmd(OP_SUB, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, "after reset");

        for (int k = 0; k < 6; k++)
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
